// File: rtl/router_pkg.sv
// Shared definitions for the router input-side packet sequencer.
package router_pkg;

    localparam int         NUM_PORTS    = 3;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

endpackage

// File: rtl/router_fsm.sv
// Packet-sequencing controller: steps each packet through decode, header,
// payload and parity phases; outputs are Moore decodes of the state register.
module router_fsm
    import router_pkg::*;
#(
    parameter int NUM_PORTS = router_pkg::NUM_PORTS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [1:0] din,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_addr,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       wr_en_reg,
    output logic       busy
);

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_addr;
    logic [NUM_PORTS-1:0] w_empty;
    logic [NUM_PORTS-1:0] w_soft;
    logic                 w_addr_ok;

    assign w_empty   = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign w_soft    = {soft_reset_2, soft_reset_1, soft_reset_0};
    assign w_addr_ok = pkt_valid && (din != ADDR_INVALID);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DECODE_ADDRESS;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE_ADDRESS && w_addr_ok)
                r_addr <= din;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            DECODE_ADDRESS: begin
                if (w_addr_ok)
                    w_next = w_empty[din] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            WAIT_TILL_EMPTY: begin
                if (w_empty[r_addr])
                    w_next = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: w_next = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)
                    w_next = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    w_next = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    w_next = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    w_next = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    w_next = LOAD_PARITY;
                else
                    w_next = LOAD_DATA;
            end
            LOAD_PARITY:        w_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:            w_next = DECODE_ADDRESS;
        endcase

        // Only the addressed port's read timeout aborts the packet in flight.
        if (r_state != DECODE_ADDRESS && w_soft[r_addr])
            w_next = DECODE_ADDRESS;
    end

    assign detect_addr = (r_state == DECODE_ADDRESS);
    assign lfd_state   = (r_state == LOAD_FIRST_DATA);
    assign ld_state    = (r_state == LOAD_DATA);
    assign laf_state   = (r_state == LOAD_AFTER_FULL);
    assign full_state  = (r_state == FIFO_FULL_STATE);
    assign rst_int_reg = (r_state == CHECK_PARITY_ERROR);
    assign wr_en_reg   = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                         (r_state == LOAD_AFTER_FULL);
    assign busy        = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm with a packet-phase reference model.
module tb_router_fsm;

    logic       clk = 1'b0;
    logic       rst, pkt_valid, fifo_full, parity_done, low_pkt_valid;
    logic [1:0] din;
    logic       e0, e1, e2, s0, s1, s2;
    logic       detect_addr, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, wr_en_reg, busy;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    router_fsm #(.NUM_PORTS(3)) dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din), .fifo_full(fifo_full),
        .fifo_empty_0(e0), .fifo_empty_1(e1), .fifo_empty_2(e2),
        .soft_reset_0(s0), .soft_reset_1(s1), .soft_reset_2(s2),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_addr(detect_addr), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .wr_en_reg(wr_en_reg), .busy(busy)
    );

    // Reference model: packet phases named by what the router is doing.
    typedef enum {P_IDLE, P_WAIT, P_HDR, P_PAY, P_STALL, P_RESUME, P_PAR, P_CHK} phase_t;
    phase_t     m_ph;
    logic [1:0] m_addr;
    bit         m_valid = 1'b0;

    function automatic phase_t model_next();
        logic [2:0] emp;
        logic [2:0] sr;
        emp = {e2, e1, e0};
        sr  = {s2, s1, s0};
        if (m_ph != P_IDLE && m_addr < 2'd3 && sr[m_addr]) return P_IDLE;
        case (m_ph)
            P_IDLE:   return (pkt_valid && din != 2'd3) ? (emp[din] ? P_HDR : P_WAIT) : P_IDLE;
            P_WAIT:   return emp[m_addr] ? P_HDR : P_WAIT;
            P_HDR:    return P_PAY;
            P_PAY:    return fifo_full ? P_STALL : (pkt_valid ? P_PAY : P_PAR);
            P_STALL:  return fifo_full ? P_STALL : P_RESUME;
            P_RESUME: return parity_done ? P_IDLE : (low_pkt_valid ? P_PAR : P_PAY);
            P_PAR:    return P_CHK;
            default:  return fifo_full ? P_STALL : P_IDLE;
        endcase
    endfunction

    // Order: detect, lfd, ld, laf, full, rst_int, wr_en, busy
    function automatic logic [7:0] expected(phase_t ph);
        logic writing;
        logic free;
        writing = (ph == P_PAY) || (ph == P_PAR) || (ph == P_RESUME);
        free    = (ph == P_IDLE) || (ph == P_PAY);
        return {ph == P_IDLE, ph == P_HDR, ph == P_PAY, ph == P_RESUME,
                ph == P_STALL, ph == P_CHK, writing, !free};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ph    <= P_IDLE;
            m_addr  <= 2'd0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            m_ph <= model_next();
            if (m_ph == P_IDLE && pkt_valid && din != 2'd3) m_addr <= din;
        end
    end

    wire [7:0] dut_vec = {detect_addr, lfd_state, ld_state, laf_state,
                          full_state, rst_int_reg, wr_en_reg, busy};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) check("model", dut_vec, expected(m_ph));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int nw, nlfd, nld, ndet, nbusy, nfull;

    initial begin
        rst = 1'b1; pkt_valid = 1'b0; din = 2'd0; fifo_full = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;
        e0 = 1'b1; e1 = 1'b1; e2 = 1'b1; s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
        repeat (2) tick();
        check("reset_outputs", dut_vec, 8'b1000_0000);
        check("reset_addr", {6'd0, dut.r_addr}, 8'd0);
        rst = 1'b0;
        tick();

        // Normal packet: header + 4 payload bytes to port 1
        din = 2'd1; pkt_valid = 1'b1;
        nw = 0; nlfd = 0; nld = 0; ndet = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 4) pkt_valid = 1'b0;
            nw   += int'(wr_en_reg);
            nlfd += int'(lfd_state);
            nld  += int'(ld_state);
            if (i < 7) ndet += int'(detect_addr);
        end
        check("pkt_wr_cycles", nw[7:0], 8'd5);
        check("pkt_lfd_cycles", nlfd[7:0], 8'd1);
        check("pkt_ld_cycles", nld[7:0], 8'd4);
        check("pkt_detect_early", ndet[7:0], 8'd0);
        check("pkt_detect_at_7", {7'd0, detect_addr}, 8'd1);

        // Busy destination: port 2 not empty for 10 cycles
        din = 2'd2; pkt_valid = 1'b1; e2 = 1'b0; nbusy = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            nbusy += int'(busy && !detect_addr && !lfd_state);
        end
        check("wait_busy_cycles", nbusy[7:0], 8'd10);
        e2 = 1'b1;
        tick();
        check("wait_to_lfd", {7'd0, lfd_state}, 8'd1);
        pkt_valid = 1'b0;
        repeat (4) tick();
        check("wait_pkt_done", {7'd0, detect_addr}, 8'd1);

        // Invalid address: stay in decode, addr keeps 2
        din = 2'd3; pkt_valid = 1'b1;
        repeat (3) tick();
        check("invalid_stay", dut_vec, 8'b1000_0000);
        check("invalid_addr", {6'd0, dut.r_addr}, 8'd2);
        pkt_valid = 1'b0;

        // FIFO full for 3 cycles mid-payload
        din = 2'd0; pkt_valid = 1'b1;
        tick(); tick();
        fifo_full = 1'b1; nfull = 0; nw = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            nfull += int'(full_state);
            nw    += int'(wr_en_reg);
        end
        fifo_full = 1'b0;
        check("full_cycles", nfull[7:0], 8'd3);
        check("full_no_write", nw[7:0], 8'd0);
        tick();
        check("laf_once", dut_vec, 8'b0001_0011);
        tick();
        check("laf_back_to_ld", dut_vec, 8'b0010_0010);
        pkt_valid = 1'b0;
        repeat (3) tick();

        // LAF with low_pkt_valid -> LP; CPE with fifo_full -> FFS; soft reset in FFS
        din = 2'd1; pkt_valid = 1'b1;
        tick(); tick();
        fifo_full = 1'b1; tick();
        fifo_full = 1'b0; low_pkt_valid = 1'b1; tick();
        tick();
        check("laf_low_to_lp", dut_vec, 8'b0000_0011);
        low_pkt_valid = 1'b0; pkt_valid = 1'b0; fifo_full = 1'b1;
        tick();
        check("lp_to_cpe", dut_vec, 8'b0000_0101);
        tick();
        check("cpe_full_to_ffs", dut_vec, 8'b0000_1001);
        s1 = 1'b1;
        tick();
        check("soft_in_ffs", dut_vec, 8'b1000_0000);
        s1 = 1'b0; fifo_full = 1'b0;

        // LAF parity_done beats low_pkt_valid
        din = 2'd0; pkt_valid = 1'b1;
        tick(); tick();
        fifo_full = 1'b1; tick();
        fifo_full = 1'b0; parity_done = 1'b1; low_pkt_valid = 1'b1; tick();
        tick();
        check("laf_parity_done", dut_vec, 8'b1000_0000);
        parity_done = 1'b0; low_pkt_valid = 1'b0; pkt_valid = 1'b0;

        // Soft reset: non-addressed ignored, addressed aborts, ignored in decode
        din = 2'd0; pkt_valid = 1'b1;
        tick(); tick();
        s1 = 1'b1; tick();
        check("soft_other_ignored", dut_vec, 8'b0010_0010);
        s1 = 1'b0; s0 = 1'b1; tick();
        check("soft_addressed", dut_vec, 8'b1000_0000);
        tick();
        check("soft_ignored_in_decode", dut_vec, 8'b0100_0001);
        tick();
        check("soft_in_lfd", dut_vec, 8'b1000_0000);
        s0 = 1'b0; pkt_valid = 1'b0;

        // rst together with soft reset while stalled
        din = 2'd1; pkt_valid = 1'b1;
        tick(); tick();
        fifo_full = 1'b1; tick();
        check("stall_before_rst", {7'd0, full_state}, 8'd1);
        rst = 1'b1; s0 = 1'b1; tick();
        check("rst_over_soft", dut_vec, 8'b1000_0000);
        check("rst_addr", {6'd0, dut.r_addr}, 8'd0);
        rst = 1'b0; s0 = 1'b0; fifo_full = 1'b0; pkt_valid = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
